// File: rtl/hazard_pkg.sv
// hazard_pkg: types and constants shared by the hazard unit and the
// post-decode pipeline stages.
//   sb_entry_t    scoreboard entry {valid, rd, is_branch}; rd is held at the
//                 widest supported register-index width and zero-extended
//   br_state_t    branch-control states
//   FWD_REGFILE   forward-select code meaning "read the register file"
//   WRITE_PAIR_W  width of the stage write-back pair bus
//   BRANCH_BUS_W  width of the branch-resolution bus
package hazard_pkg;

    // Widest register index the scoreboard can hold (REG_BITS must not exceed it).
    localparam int unsigned SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_branch;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT  = 2'd1,
        FLUSH_ST = 2'd2
    } br_state_t;

    localparam int unsigned FWD_REGFILE  = 0;
    localparam int unsigned WRITE_PAIR_W = 38;
    localparam int unsigned BRANCH_BUS_W = 33;

endpackage

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// fwd_select: combinational priority match of one decode source register
// against the scoreboard. The youngest valid entry (lowest index) whose rd
// equals the source wins; register 0 never matches.
//   entry_valid  in   per-stage scoreboard valid bits
//   entry_rd     in   per-stage scoreboard destination registers
//   src          in   decode source register
//   stage_ready  in   per-stage result-valid bits
//   stage_data   in   packed per-stage results, stage i at [i*DATA_W +: DATA_W]
//   sel          out  0 = register file, k = stage k-1
//   data         out  forwarded value (0 when sel = 0)
//   hazard       out  winning entry's result is not ready yet
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SEL_W    = 4
) (
    input  logic [STAGES-1:0]              entry_valid,
    input  logic [STAGES-1:0][SB_RD_W-1:0] entry_rd,
    input  logic [REG_BITS-1:0]            src,
    input  logic [STAGES-1:0]              stage_ready,
    input  logic [STAGES*DATA_W-1:0]       stage_data,
    output logic [SEL_W-1:0]               sel,
    output logic [DATA_W-1:0]              data,
    output logic                           hazard
);

    logic found;

    always_comb begin
        sel    = SEL_W'(FWD_REGFILE);
        data   = '0;
        hazard = 1'b0;
        found  = 1'b0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (!found && src != '0 && entry_valid[i] &&
                entry_rd[i] == SB_RD_W'(src)) begin
                found  = 1'b1;
                sel    = SEL_W'(i + 1);
                data   = stage_data[i*DATA_W +: DATA_W];
                // An older ready copy must not mask a younger unready one,
                // so only the winner decides the hazard.
                hazard = !stage_ready[i];
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: scoreboard-based hazard unit between decode and the
// post-decode stages. Tracks pending register writes per stage, resolves
// RS/RT forwarding, stalls on unready RAW dependencies and controls branches
// (BRANCH_MODE 0: stall until resolved; 1: predict-not-taken with flush).
//   CLOCK            in   rising-edge clock
//   RESET            in   asynchronous active-low reset
//   ENABLE           in   advance enable; 0 holds all state
//   ISSUE_VALID      in   decode presents an instruction
//   ISSUE_RD         in   destination register (0 = no write)
//   ISSUE_IS_BRANCH  in   issued instruction is a branch/jump
//   SRC_RS, SRC_RT   in   decode source registers
//   STAGE_READY      in   bit i: stage i result valid on STAGE_DATA
//   STAGE_DATA       in   packed per-stage results
//   BRANCH_VALID     in   branch resolved this cycle
//   BRANCH_TAKEN     in   resolved branch was taken
//   STALL            out  hold fetch/decode, inject bubble
//   FLUSH            out  kill fetch/decode contents
//   FWD_RS/RT_SEL    out  0 = register file, k = stage k-1
//   FWD_RS/RT_DATA   out  forwarded value
//   PENDING          out  valid scoreboard entries with rd != 0
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned REG_BITS    = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned BRANCH_MODE = 0,
    parameter int unsigned SEL_W       = 4
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       ENABLE,
    input  logic                       ISSUE_VALID,
    input  logic [REG_BITS-1:0]        ISSUE_RD,
    input  logic                       ISSUE_IS_BRANCH,
    input  logic [REG_BITS-1:0]        SRC_RS,
    input  logic [REG_BITS-1:0]        SRC_RT,
    input  logic [STAGES-1:0]          STAGE_READY,
    input  logic [STAGES*DATA_W-1:0]   STAGE_DATA,
    input  logic                       BRANCH_VALID,
    input  logic                       BRANCH_TAKEN,
    output logic                       STALL,
    output logic                       FLUSH,
    output logic [SEL_W-1:0]           FWD_RS_SEL,
    output logic [SEL_W-1:0]           FWD_RT_SEL,
    output logic [DATA_W-1:0]          FWD_RS_DATA,
    output logic [DATA_W-1:0]          FWD_RT_DATA,
    output logic [SEL_W-1:0]           PENDING
);

    sb_entry_t [STAGES-1:0]         sb_q;
    sb_entry_t [STAGES-1:0]         sb_d;
    br_state_t                      state_q;
    br_state_t                      state_d;
    logic [STAGES-1:0]              sb_valid;
    logic [STAGES-1:0][SB_RD_W-1:0] sb_rd;
    logic [STAGES-1:0]              kill;
    logic                           older_branch;
    logic                           rs_hazard;
    logic                           rt_hazard;
    logic                           br_taken;
    logic                           flush_now;
    logic                           stall_now;
    logic                           issue_accept;
    logic [SEL_W-1:0]               pending_cnt;

    assign br_taken = BRANCH_VALID & BRANCH_TAKEN;

    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            sb_valid[i] = sb_q[i].valid;
            sb_rd[i]    = sb_q[i].rd;
        end
    end

    fwd_select #(
        .STAGES   (STAGES),
        .REG_BITS (REG_BITS),
        .DATA_W   (DATA_W),
        .SEL_W    (SEL_W)
    ) u_fwd_rs (
        .entry_valid (sb_valid),
        .entry_rd    (sb_rd),
        .src         (SRC_RS),
        .stage_ready (STAGE_READY),
        .stage_data  (STAGE_DATA),
        .sel         (FWD_RS_SEL),
        .data        (FWD_RS_DATA),
        .hazard      (rs_hazard)
    );

    fwd_select #(
        .STAGES   (STAGES),
        .REG_BITS (REG_BITS),
        .DATA_W   (DATA_W),
        .SEL_W    (SEL_W)
    ) u_fwd_rt (
        .entry_valid (sb_valid),
        .entry_rd    (sb_rd),
        .src         (SRC_RT),
        .stage_ready (STAGE_READY),
        .stage_data  (STAGE_DATA),
        .sel         (FWD_RT_SEL),
        .data        (FWD_RT_DATA),
        .hazard      (rt_hazard)
    );

    // Branch control: outputs and next state.
    always_comb begin
        // In predict-not-taken mode FLUSH_ST is the extra bubble after the
        // combinational flush, so FLUSH covers both cycles there as well.
        flush_now    = (state_q == FLUSH_ST) || (BRANCH_MODE != 0 && br_taken);
        stall_now    = !flush_now && (rs_hazard || rt_hazard || state_q == BR_WAIT);
        issue_accept = ISSUE_VALID && !stall_now && !flush_now;

        state_d = state_q;
        if (ENABLE) begin
            if (BRANCH_MODE != 0) begin
                state_d = br_taken ? FLUSH_ST : RUN;
            end else begin
                unique case (state_q)
                    RUN:      if (issue_accept && ISSUE_IS_BRANCH) state_d = BR_WAIT;
                    BR_WAIT:  if (BRANCH_VALID) state_d = BRANCH_TAKEN ? FLUSH_ST : RUN;
                    FLUSH_ST: state_d = RUN;
                    default:  state_d = RUN;
                endcase
            end
        end
    end

    // Taken-branch kill mask: every entry below (younger than) the oldest
    // valid branch. Scanning from the oldest end, an entry is killed once any
    // older valid branch has been seen.
    always_comb begin
        kill         = '0;
        older_branch = 1'b0;
        if (BRANCH_MODE != 0 && br_taken) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                kill[STAGES-1-k] = older_branch;
                older_branch     = older_branch |
                                   (sb_q[STAGES-1-k].valid & sb_q[STAGES-1-k].is_branch);
            end
        end
    end

    // Scoreboard advance.
    always_comb begin
        sb_d = sb_q;
        if (ENABLE) begin
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (kill[i-1]) sb_d[i] = '0;
                else           sb_d[i] = sb_q[i-1];
            end
            sb_d[0] = '0;
            if (issue_accept) begin
                sb_d[0].valid     = 1'b1;
                sb_d[0].rd        = SB_RD_W'(ISSUE_RD);
                sb_d[0].is_branch = ISSUE_IS_BRANCH;
            end
        end
    end

    // At most STAGES entries exist, so the count never exceeds STAGES.
    always_comb begin
        pending_cnt = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (sb_q[i].valid && sb_q[i].rd != '0) pending_cnt = pending_cnt + SEL_W'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            sb_q    <= '0;
            state_q <= RUN;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
        end
    end

    assign STALL   = stall_now;
    assign FLUSH   = flush_now;
    assign PENDING = pending_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

    localparam int STG = 3;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst_n, enable, issue_valid, issue_is_branch, branch_valid, branch_taken;
    logic [4:0] issue_rd, src_rs, src_rt;
    logic [STG-1:0] stage_ready;
    logic [STG*DW-1:0] stage_data;

    logic [1:0] d_stall, d_flush;
    logic [1:0][3:0] d_rs_sel, d_rt_sel, d_pend;
    logic [1:0][DW-1:0] d_rs_data, d_rt_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .STAGES(STG), .REG_BITS(5), .DATA_W(DW), .BRANCH_MODE(0), .SEL_W(4)
    ) u_dut0 (
        .CLOCK(clk), .RESET(rst_n), .ENABLE(enable), .ISSUE_VALID(issue_valid),
        .ISSUE_RD(issue_rd), .ISSUE_IS_BRANCH(issue_is_branch), .SRC_RS(src_rs),
        .SRC_RT(src_rt), .STAGE_READY(stage_ready), .STAGE_DATA(stage_data),
        .BRANCH_VALID(branch_valid), .BRANCH_TAKEN(branch_taken),
        .STALL(d_stall[0]), .FLUSH(d_flush[0]), .FWD_RS_SEL(d_rs_sel[0]),
        .FWD_RT_SEL(d_rt_sel[0]), .FWD_RS_DATA(d_rs_data[0]), .FWD_RT_DATA(d_rt_data[0]),
        .PENDING(d_pend[0])
    );

    pipeline_hazard_unit #(
        .STAGES(STG), .REG_BITS(5), .DATA_W(DW), .BRANCH_MODE(1), .SEL_W(4)
    ) u_dut1 (
        .CLOCK(clk), .RESET(rst_n), .ENABLE(enable), .ISSUE_VALID(issue_valid),
        .ISSUE_RD(issue_rd), .ISSUE_IS_BRANCH(issue_is_branch), .SRC_RS(src_rs),
        .SRC_RT(src_rt), .STAGE_READY(stage_ready), .STAGE_DATA(stage_data),
        .BRANCH_VALID(branch_valid), .BRANCH_TAKEN(branch_taken),
        .STALL(d_stall[1]), .FLUSH(d_flush[1]), .FWD_RS_SEL(d_rs_sel[1]),
        .FWD_RT_SEL(d_rt_sel[1]), .FWD_RS_DATA(d_rs_data[1]), .FWD_RT_DATA(d_rt_data[1]),
        .PENDING(d_pend[1])
    );

    // ---------------- reference model (index m = branch mode) ----------------
    bit m_v  [2][STG];
    int m_rd [2][STG];
    bit m_br [2][STG];
    bit m_wait [2];      // mode 0: waiting for an issued branch to resolve
    bit m_fb   [2];      // a flush bubble is owed this cycle

    bit          e_stall, e_flush;
    int          e_rs_sel, e_rt_sel, e_pend;
    logic [31:0] e_rs_data, e_rt_data;

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s mode=%0d t=%0t got=0x%0h want=0x%0h", name, m, $time, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            m_wait[m] = 0;
            m_fb[m]   = 0;
            for (int i = 0; i < STG; i++) begin
                m_v[m][i] = 0; m_rd[m][i] = 0; m_br[m][i] = 0;
            end
        end
    endfunction

    function automatic void lookup(input int m, input int src, output int sel,
                                   output logic [31:0] data, output bit haz);
        sel = 0; data = 0; haz = 0;
        if (src == 0) return;
        for (int i = 0; i < STG; i++) begin
            if (m_v[m][i] && m_rd[m][i] == src) begin
                sel  = i + 1;
                data = stage_data[i*DW +: DW];
                haz  = !stage_ready[i];
                return;
            end
        end
    endfunction

    function automatic void model_eval(input int m);
        bit hz_rs, hz_rt;
        lookup(m, int'(src_rs), e_rs_sel, e_rs_data, hz_rs);
        lookup(m, int'(src_rt), e_rt_sel, e_rt_data, hz_rt);
        e_flush = m_fb[m] || (m == 1 && branch_valid && branch_taken);
        e_stall = !e_flush && (hz_rs || hz_rt || m_wait[m]);
        e_pend  = 0;
        for (int i = 0; i < STG; i++) if (m_v[m][i] && m_rd[m][i] != 0) e_pend++;
        if (e_pend > STG) e_pend = STG;
    endfunction

    function automatic void model_step(input int m);
        bit accept, taken;
        int oldest;
        model_eval(m);
        accept = issue_valid && !e_stall && !e_flush;
        taken  = branch_valid && branch_taken;
        if (m == 1 && taken) begin
            oldest = -1;
            for (int i = 0; i < STG; i++) if (m_v[m][i] && m_br[m][i]) oldest = i;
            for (int i = 0; i < oldest; i++) m_v[m][i] = 0;
        end
        for (int i = STG - 1; i > 0; i--) begin
            m_v[m][i] = m_v[m][i-1]; m_rd[m][i] = m_rd[m][i-1]; m_br[m][i] = m_br[m][i-1];
        end
        m_v[m][0]  = accept;
        m_rd[m][0] = accept ? int'(issue_rd) : 0;
        m_br[m][0] = accept && issue_is_branch;
        if (m == 0) begin
            if (m_fb[m]) m_fb[m] = 0;
            else if (m_wait[m]) begin
                if (branch_valid) begin m_wait[m] = 0; m_fb[m] = branch_taken; end
            end else if (accept && issue_is_branch) m_wait[m] = 1;
        end else begin
            m_fb[m] = taken;
        end
    endfunction

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) model_clear();
            for (int m = 0; m < 2; m++) begin
                model_eval(m);
                chk("stall",   m, 32'(d_stall[m]),  32'(e_stall));
                chk("flush",   m, 32'(d_flush[m]),  32'(e_flush));
                chk("rs_sel",  m, 32'(d_rs_sel[m]), e_rs_sel);
                chk("rt_sel",  m, 32'(d_rt_sel[m]), e_rt_sel);
                chk("rs_data", m, d_rs_data[m],     e_rs_data);
                chk("rt_data", m, d_rt_data[m],     e_rt_data);
                chk("pending", m, 32'(d_pend[m]),   e_pend);
            end
            @(posedge clk);
            if (!rst_n) model_clear();
            else if (enable) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rd = 0; issue_is_branch = 0;
        src_rs = 0; src_rt = 0; stage_ready = '1; stage_data = '0;
        branch_valid = 0; branch_taken = 0;
    endtask

    task automatic put_issue(input logic [4:0] rd, input logic br);
        issue_valid = 1; issue_rd = rd; issue_is_branch = br;
    endtask

    initial begin
        rst_n = 0; enable = 1; idle_inputs();
        #2;
        for (int m = 0; m < 2; m++) begin
            chk("rst_stall", m, 32'(d_stall[m]), 0);
            chk("rst_flush", m, 32'(d_flush[m]), 0);
            chk("rst_pend",  m, 32'(d_pend[m]),  0);
        end
        cyc(); cyc();
        rst_n = 1;
        cyc();

        // back-to-back dependency
        put_issue(3, 0); cyc();
        idle_inputs(); src_rs = 3; stage_data[31:0] = 32'h11; #1;
        chk("b2b_sel", 0, 32'(d_rs_sel[0]), 1);
        chk("b2b_data", 0, d_rs_data[0], 32'h11);
        chk("b2b_stall", 0, 32'(d_stall[0]), 0);
        cyc();

        // load-use
        idle_inputs(); put_issue(5, 0); cyc();
        idle_inputs(); put_issue(7, 0); src_rt = 5; stage_ready = 3'b110; #1;
        chk("lu_stall", 0, 32'(d_stall[0]), 1);
        cyc();
        idle_inputs(); put_issue(7, 0); src_rt = 5; stage_data[63:32] = 32'hAB; #1;
        chk("lu_sel", 0, 32'(d_rt_sel[0]), 2);
        chk("lu_data", 0, d_rt_data[0], 32'hAB);
        chk("lu_stall2", 0, 32'(d_stall[0]), 0);
        cyc();

        // youngest wins, r0 never matches
        idle_inputs(); put_issue(0, 0); cyc();
        idle_inputs(); put_issue(7, 0); cyc();
        idle_inputs(); src_rs = 7; src_rt = 0; stage_ready = 3'b101;
        stage_data[31:0] = 32'h1; stage_data[95:64] = 32'h2; #1;
        chk("yw_sel", 0, 32'(d_rs_sel[0]), 1);
        chk("yw_data", 0, d_rs_data[0], 32'h1);
        chk("r0_sel", 0, 32'(d_rt_sel[0]), 0);
        chk("r0_stall", 0, 32'(d_stall[0]), 0);
        chk("yw_pend", 0, 32'(d_pend[0]), 2);
        cyc();

        // taken branch, both modes
        idle_inputs(); put_issue(0, 1); cyc();
        idle_inputs(); put_issue(4, 0); #1;
        chk("m0_brwait_stall", 0, 32'(d_stall[0]), 1);
        chk("m1_no_stall", 1, 32'(d_stall[1]), 0);
        cyc();
        idle_inputs(); branch_valid = 1; branch_taken = 1; #1;
        chk("m0_resolve_stall", 0, 32'(d_stall[0]), 1);
        chk("m0_resolve_flush", 0, 32'(d_flush[0]), 0);
        chk("m1_taken_flush", 1, 32'(d_flush[1]), 1);
        chk("m1_taken_stall", 1, 32'(d_stall[1]), 0);
        chk("m1_pend_before", 1, 32'(d_pend[1]), 1);
        cyc();
        idle_inputs(); put_issue(9, 0); src_rs = 4; #1;
        chk("m0_flush_pulse", 0, 32'(d_flush[0]), 1);
        chk("m0_flush_nostall", 0, 32'(d_stall[0]), 0);
        chk("m1_pend_after", 1, 32'(d_pend[1]), 0);
        chk("m1_killed_sel", 1, 32'(d_rs_sel[1]), 0);
        cyc();
        idle_inputs(); #1;
        chk("m0_flush_end", 0, 32'(d_flush[0]), 0);
        chk("m0_run_stall", 0, 32'(d_stall[0]), 0);
        chk("m0_discard_pend", 0, 32'(d_pend[0]), 0);
        chk("m1_discard_pend", 1, 32'(d_pend[1]), 0);
        cyc();

        // not-taken branch, mode 0
        idle_inputs(); put_issue(0, 1); cyc();
        idle_inputs(); branch_valid = 1; branch_taken = 0; #1;
        chk("nt_stall", 0, 32'(d_stall[0]), 1);
        chk("nt_flush", 0, 32'(d_flush[0]), 0);
        chk("nt_flush_m1", 1, 32'(d_flush[1]), 0);
        cyc();
        idle_inputs(); put_issue(2, 0); #1;
        chk("nt_run_flush", 0, 32'(d_flush[0]), 0);
        chk("nt_run_stall", 0, 32'(d_stall[0]), 0);
        cyc();

        // reset in the middle of BR_WAIT
        idle_inputs(); put_issue(31, 1); cyc();
        idle_inputs(); #1;
        chk("pre_rst_stall", 0, 32'(d_stall[0]), 1);
        chk("pre_rst_pend0", 0, 32'(d_pend[0]), 2);
        chk("pre_rst_pend1", 1, 32'(d_pend[1]), 2);
        rst_n = 0; #1;
        for (int m = 0; m < 2; m++) begin
            chk("arst_stall", m, 32'(d_stall[m]), 0);
            chk("arst_flush", m, 32'(d_flush[m]), 0);
            chk("arst_pend",  m, 32'(d_pend[m]),  0);
        end
        cyc(); cyc();
        rst_n = 1; #1;
        for (int m = 0; m < 2; m++) chk("post_rst_flush", m, 32'(d_flush[m]), 0);
        cyc(); #1;
        for (int m = 0; m < 2; m++) chk("post_rst_flush2", m, 32'(d_flush[m]), 0);
        cyc();

        // enable low holds state
        enable = 0; put_issue(6, 0); cyc();
        idle_inputs(); enable = 1; src_rs = 6; #1;
        chk("hold_sel", 0, 32'(d_rs_sel[0]), 0);
        chk("hold_pend", 0, 32'(d_pend[0]), 0);
        cyc();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle_inputs();
            enable          = ($urandom_range(9) != 0);
            issue_valid     = ($urandom_range(3) != 0);
            issue_rd        = 5'($urandom_range(7));
            issue_is_branch = ($urandom_range(7) == 0);
            src_rs          = 5'($urandom_range(7));
            src_rt          = 5'($urandom_range(7));
            stage_ready     = 3'($urandom);
            stage_data      = {$urandom, $urandom, $urandom};
            branch_valid    = ($urandom_range(5) == 0);
            branch_taken    = 1'($urandom_range(1));
            rst_n           = ($urandom_range(299) != 0);
            cyc();
        end

        idle_inputs(); rst_n = 1; enable = 1;
        cyc(); cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the single-signal branch-stall hazard unit of the MIPS pipeline.
- Sits between decode and the post-decode stages (ALU, memory, writeback).
- Keeps a per-stage scoreboard of pending register writes and resolves operand forwarding for RS/RT over STAGES result buses.
- Raises STALL on RAW hazards whose data is not yet ready, such as load-use.
- Handles branches either stall-until-resolve (BRANCH_MODE=0) or predict-not-taken with flush (BRANCH_MODE=1).

Parameters:
STAGES, 3, post-decode stages tracked (entry 0 = ALU stage, entry STAGES-1 = writeback); range 2..8
REG_BITS, 5, register index width
DATA_W, 32, register data width
BRANCH_MODE, 0, 0 = stall on issued branch until resolved; 1 = predict-not-taken, flush on taken
SEL_W, 4, forward-select width; must satisfy 2^SEL_W > STAGES

Ports:
CLOCK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
ENABLE  in  1  global advance enable; when 0 all state holds
ISSUE_VALID  in  1  decode presents an instruction this cycle
ISSUE_RD  in  REG_BITS  destination register; 0 = no write
ISSUE_IS_BRANCH  in  1  issued instruction is a branch/jump
SRC_RS  in  REG_BITS  decode source register A
SRC_RT  in  REG_BITS  decode source register B
STAGE_READY  in  STAGES  bit i: result of stage i is valid on STAGE_DATA
STAGE_DATA  in  STAGES*DATA_W  packed per-stage results, stage i at [i*DATA_W +: DATA_W]
BRANCH_VALID  in  1  branch resolved this cycle (from writeback)
BRANCH_TAKEN  in  1  qualified by BRANCH_VALID
STALL  out  1  hold fetch/decode, inject bubble
FLUSH  out  1  one-cycle kill of fetch/decode contents
FWD_RS_SEL  out  SEL_W  0 = register file, k = stage k-1
FWD_RT_SEL  out  SEL_W  as above
FWD_RS_DATA  out  DATA_W  forwarded value (0 when SEL = 0)
FWD_RT_DATA  out  DATA_W  as above
PENDING  out  SEL_W  count of valid scoreboard entries with rd != 0

Behaviour:
Reset and entry format:
- Reset (RESET low, asynchronous) clears all scoreboard entries and sets state to RUN. STALL=0, FLUSH=0, PENDING=0.
- Scoreboard entry: {valid, rd, is_branch}.

Scoreboard advance (ENABLE=1):
- Entries shift i -> i+1; entry STAGES-1 retires.
- Entry 0 loads the issued instruction if ISSUE_VALID & !STALL & !FLUSH; otherwise it loads a bubble (valid=0).
- ENABLE=0: no shift, no state change; combinational outputs still track inputs.

Forwarding (combinational, registered state only):
- For each source, the youngest valid entry i (lowest index) with rd == src and src != 0 wins. SEL = i+1, DATA = STAGE_DATA slice i.
- No match: SEL = 0, DATA = 0.
- Register 0 never matches and never hazards.

Data hazard:
- STALL asserts when a winning entry has STAGE_READY[i]=0.
- An older ready entry never overrides a younger unready one.

Branch FSM, states RUN, BR_WAIT, FLUSH_ST:
- BRANCH_MODE=0:
  - RUN -> BR_WAIT when a branch issues.
  - In BR_WAIT, STALL=1 and no issue is accepted.
  - BR_WAIT -> FLUSH_ST on BRANCH_VALID&BRANCH_TAKEN.
  - BR_WAIT -> RUN on BRANCH_VALID&!BRANCH_TAKEN.
  - FLUSH_ST: FLUSH=1 for exactly one cycle, STALL=0, then RUN.
- BRANCH_MODE=1:
  - BR_WAIT is unused; issue continues past branches.
  - On BRANCH_VALID&BRANCH_TAKEN, every valid entry younger than the oldest valid is_branch entry is invalidated in the same edge. FLUSH=1 that cycle (combinational) and the state goes to FLUSH_ST for one further bubble.
- BRANCH_VALID while in RUN in mode 0 (spurious) is ignored.

Simultaneous events:
- A taken branch has priority over a data stall: FLUSH=1 forces STALL=0.
- Issue in the same cycle as FLUSH is discarded.

PENDING:
- Updated each edge; saturates at STAGES.

Reset mid-operation:
- Clears BR_WAIT and flush state immediately.
- No FLUSH pulse after reset deassertion.

Decomposition:
- Shared package hazard_pkg holds:
  - typedef sb_entry_t {valid, rd, is_branch};
  - enum br_state_t {RUN, BR_WAIT, FLUSH_ST};
  - constant FWD_REGFILE = 0;
  - write-pair and branch-bus widths (38, 33) shared with the pipeline stages.
- One sub-module, fwd_select: a combinational priority match of one source against the scoreboard. It is instantiated twice, for RS and RT.

Test Plan:
- Back-to-back dependency: issue add rd=3, then use rs=3 with STAGE_READY[0]=1, STAGE_DATA stage0=0x11 -> FWD_RS_SEL=1, FWD_RS_DATA=0x11, STALL=0.
- Load-use: issue rd=5 with STAGE_READY[0]=0, next rt=5 -> STALL=1 for one cycle. When the entry reaches stage 1 with READY[1]=1, data 0xAB -> SEL=2, DATA=0xAB, STALL=0.
- Youngest wins and r0: entries rd=7 at stage 0 (0x1) and stage 2 (0x2), src=7 -> SEL=1, DATA=0x1. src=0 with an entry rd=0 -> SEL=0, STALL=0.
- Mode 0 branch: issue branch -> STALL=1 until BRANCH_VALID&TAKEN, then FLUSH=1 for exactly 1 cycle and STALL=0. Not-taken -> no FLUSH, RUN next cycle.
- Mode 1 taken: branch at stage 1, valid younger rd=4 at stage 0 -> after BRANCH_VALID&TAKEN the stage 0 entry is invalid, PENDING decrements, a src=4 lookup gives SEL=0.
- Reset mid-BR_WAIT: drop RESET low -> STALL=0, FLUSH=0, PENDING=0 asynchronously. After release, no FLUSH appears.
